// File: rtl/tail_light_sequencer.sv
// Sequential turn-signal controller: thermometer sweep per side, prescaled step tick, hazard blink.
// Optional brake overlay enabled by defining TAIL_LIGHT_BRAKE_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no request; banks dark, prescaler held at 0
// S_RUN     | sweeping the bank selected by dir; step lamps lit
// S_DARK    | sweep finished; both banks dark for one step period
// S_HAZ_ON  | hazard blink, both banks lit
// S_HAZ_OFF | hazard blink, both banks dark
module tail_light_sequencer #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 6_250_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] light_left,
  output logic [LAMPS-1:0] light_right,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DARK    = 3'd2,
    S_HAZ_ON  = 3'd3,
    S_HAZ_OFF = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic            dir, dir_nxt;
  logic [SW-1:0]   step, step_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic            tick;

  logic [LAMPS-1:0] pat_left, pat_right;
  logic [LAMPS-1:0] pat_left_nxt, pat_right_nxt;
  logic [LAMPS-1:0] therm;
  logic             busy_nxt;

  assign tick = (presc == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dir       <= 1'b0;
      step      <= '0;
      presc     <= '0;
      pat_left  <= '0;
      pat_right <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      step      <= step_nxt;
      presc     <= presc_nxt;
      pat_left  <= pat_left_nxt;
      pat_right <= pat_right_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    step_nxt  = step;
    case (state)
      S_IDLE: begin
        if (hazard) begin
          state_nxt = S_HAZ_ON;
        end else if (left ^ right) begin
          state_nxt = S_RUN;
          step_nxt  = SW'(1);
          dir_nxt   = right;
        end
      end
      S_RUN: begin
        if (hazard) begin
          state_nxt = S_HAZ_ON;
        end else if (tick) begin
          if (step < STEP_LAST) step_nxt = step + SW'(1);
          else                  state_nxt = S_DARK;
        end
      end
      S_DARK: begin
        if (hazard)    state_nxt = S_HAZ_ON;
        else if (tick) state_nxt = S_IDLE;
      end
      S_HAZ_ON: begin
        if (!hazard)   state_nxt = S_IDLE;
        else if (tick) state_nxt = S_HAZ_OFF;
      end
      S_HAZ_OFF: begin
        if (!hazard)   state_nxt = S_IDLE;
        else if (tick) state_nxt = S_HAZ_ON;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != S_RUN) step_nxt = '0;

    // Prescaler restarts on every state change so each phase gets a full TICK_DIV.
    if (state_nxt != state || state_nxt == S_IDLE || tick) presc_nxt = '0;
    else                                                   presc_nxt = presc + PW'(1);
  end

  always_comb begin
    therm = '0;
    for (int i = 0; i < LAMPS; i++) begin
      therm[i] = (i < int'(step_nxt));
    end

    pat_left_nxt  = '0;
    pat_right_nxt = '0;
    case (state_nxt)
      S_RUN: begin
        if (dir_nxt) pat_right_nxt = therm;
        else         pat_left_nxt  = therm;
      end
      S_HAZ_ON: begin
        pat_left_nxt  = '1;
        pat_right_nxt = '1;
      end
      default: ;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

`ifdef TAIL_LIGHT_BRAKE_EN
  logic haz_active;
  logic left_sweeping;
  logic right_sweeping;

  assign haz_active     = (state == S_HAZ_ON) || (state == S_HAZ_OFF);
  assign left_sweeping  = (state == S_RUN) && !dir;
  assign right_sweeping = (state == S_RUN) &&  dir;

  // Brake lights any bank that is not sweeping; hazard blinking takes precedence.
  assign light_left  = (brake && !haz_active && !left_sweeping)  ? '1 : pat_left;
  assign light_right = (brake && !haz_active && !right_sweeping) ? '1 : pat_right;
`else
  logic unused_brake;
  assign unused_brake = brake;
  assign light_left   = pat_left;
  assign light_right  = pat_right;
`endif

endmodule
